pulse_stretcher: RTL and testbench



---
 rtl/pulse_stretcher_pkg.sv | 13 +
 rtl/pulse_stretcher_dur_counter.sv | 35 +++
 rtl/pulse_stretcher.sv | 142 ++++++++++++++
 tb/tb_pulse_stretcher.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and constants for the pulse stretcher and its duration counter.
// The counter width is also used by the debounce blocks that reuse dur_counter.
package pulse_stretcher_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_e;

endpackage

// File: rtl/pulse_stretcher_dur_counter.sv
// Loadable down-counter with a zero flag. It saturates at zero and load wins over en.
// Also reused by the debounce blocks.
module dur_counter
    import pulse_stretcher_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (en && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle triggers into HIGH_CYCLES-high / LOW_CYCLES-low waveforms.
// Triggers that arrive while a waveform is in progress are queued as a count and replayed in order.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 2,
    parameter int PEND_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig,
    input  logic              clr,
    output logic              q,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam logic [CNT_W-1:0]  HIGH_LD  = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LOW_LD   = CNT_W'(LOW_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    state_e            state_q, state_d;
    logic              q_q, q_d;
    logic              busy_q, busy_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overflow_q, overflow_d;

    logic              cnt_load, cnt_en, cnt_zero;
    logic [CNT_W-1:0]  cnt_val;
    logic              deq, enq;

    dur_counter #(.W(CNT_W)) u_dur (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        cnt_en     = 1'b0;
        deq        = 1'b0;
        enq        = 1'b0;

        if (clr) begin
            state_d    = S_IDLE;
            q_d        = 1'b0;
            pending_d  = '0;
            overflow_d = 1'b0;
            cnt_load   = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // A queued event left over from a LOW->IDLE edge is started here.
                    if (trig || (pending_q != '0)) begin
                        state_d  = S_HIGH;
                        q_d      = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = HIGH_LD;
                        deq      = (pending_q != '0);
                    end
                end
                S_HIGH: begin
                    if (cnt_zero) begin
                        state_d  = S_LOW;
                        q_d      = 1'b0;
                        cnt_load = 1'b1;
                        cnt_val  = LOW_LD;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                S_LOW: begin
                    if (cnt_zero) begin
                        if (pending_q != '0) begin
                            state_d  = S_HIGH;
                            q_d      = 1'b1;
                            cnt_load = 1'b1;
                            cnt_val  = HIGH_LD;
                            deq      = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    q_d     = 1'b0;
                end
            endcase

            // In IDLE with an empty queue the trigger starts directly instead of queueing.
            enq = trig && ((state_q != S_IDLE) || (pending_q != '0));

            unique case ({enq, deq})
                2'b10: begin
                    if (pending_q == PEND_MAX)
                        overflow_d = 1'b1;
                    else
                        pending_d = pending_q + 1'b1;
                end
                2'b01:   pending_d = pending_q - 1'b1;
                default: pending_d = pending_q;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            q_q        <= 1'b0;
            busy_q     <= 1'b0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            busy_q     <= busy_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign q        = q_q;
    assign busy     = busy_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed self-checking bench for pulse_stretcher (HIGH=4, LOW=2, PEND_W=3).
module tb_pulse_stretcher;

    logic       clk;
    logic       rst_n;
    logic       trig;
    logic       clr;
    logic       q;
    logic       busy;
    logic [2:0] pending;
    logic       overflow;

    int tests = 0;
    int fails = 0;

    pulse_stretcher #(.HIGH_CYCLES(4), .LOW_CYCLES(2), .PEND_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .trig     (trig),
        .clr      (clr),
        .q        (q),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks q/busy against per-cycle strings, advancing one cycle after each position.
    task automatic wave(input string tag, input string qs, input string bs);
        for (int i = 0; i < qs.len(); i++) begin
            chk($sformatf("%s_q%0d", tag, i), {31'd0, q}, {31'd0, qs.getc(i) == "1"});
            chk($sformatf("%s_busy%0d", tag, i), {31'd0, busy}, {31'd0, bs.getc(i) == "1"});
            tick();
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        int   rises;
        int   guard;
        logic prev;

        rst_n = 1'b0;
        trig  = 1'b0;
        clr   = 1'b0;
        #1;
        chk("rst_q", {31'd0, q}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_pending", {29'd0, pending}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        #20 rst_n = 1'b1;
        repeat (3) tick();

        // Single trigger: 4 high, 2 low, then idle.
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("single_pending", {29'd0, pending}, 0);
        wave("single", "1111000", "1111110");
        chk("single_pending_end", {29'd0, pending}, 0);

        // Three back-to-back triggers: three phases with no idle gap.
        trig = 1'b1;
        tick();
        chk("three_q_c11", {31'd0, q}, 1);
        tick();
        tick();
        trig = 1'b0;
        chk("three_pending", {29'd0, pending}, 2);
        wave("three", "11001111001111000", "11111111111111110");
        chk("three_pending_end", {29'd0, pending}, 0);

        // Queue saturation and overflow.
        trig = 1'b1;
        repeat (6) tick();
        chk("ovf_pending5", {29'd0, pending}, 5);
        trig = 1'b0;
        tick();
        chk("ovf_pending4", {29'd0, pending}, 4);
        trig = 1'b1;
        repeat (3) tick();
        chk("ovf_pending7", {29'd0, pending}, 7);
        chk("ovf_flag_before", {31'd0, overflow}, 0);
        tick();
        trig = 1'b0;
        chk("ovf_pending_sat", {29'd0, pending}, 7);
        chk("ovf_flag", {31'd0, overflow}, 1);
        rises = 0;
        guard = 0;
        prev  = q;
        while (busy && guard < 100) begin
            tick();
            if (q && !prev) rises++;
            prev = q;
            guard++;
        end
        chk("ovf_idle_reached", {31'd0, busy}, 0);
        chk("ovf_replayed", rises, 7);
        chk("ovf_pending_end", {29'd0, pending}, 0);
        chk("ovf_sticky", {31'd0, overflow}, 1);
        do_clr();
        chk("ovf_cleared", {31'd0, overflow}, 0);

        // Trigger on a dequeue edge with a full queue: cancels, no overflow.
        trig = 1'b1;
        repeat (6) tick();
        trig = 1'b0;
        tick();
        trig = 1'b1;
        repeat (3) tick();
        trig = 1'b0;
        chk("deq_pending7", {29'd0, pending}, 7);
        tick();
        tick();
        chk("deq_q_low", {31'd0, q}, 0);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("deq_pending_same", {29'd0, pending}, 7);
        chk("deq_no_overflow", {31'd0, overflow}, 0);
        chk("deq_q_high", {31'd0, q}, 1);

        // Trigger on the LOW->IDLE edge is queued, then started from IDLE.
        do_clr();
        tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (5) tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("edge_idle_busy", {31'd0, busy}, 0);
        chk("edge_idle_pending", {29'd0, pending}, 1);
        chk("edge_idle_q", {31'd0, q}, 0);
        tick();
        chk("edge_start_q", {31'd0, q}, 1);
        chk("edge_start_pending", {29'd0, pending}, 0);
        repeat (8) tick();

        // clr during HIGH with pending=2; simultaneous trig is ignored.
        trig = 1'b1;
        repeat (3) tick();
        chk("clr_pre_pending", {29'd0, pending}, 2);
        clr = 1'b1;
        tick();
        clr  = 1'b0;
        trig = 1'b0;
        chk("clr_q", {31'd0, q}, 0);
        chk("clr_busy", {31'd0, busy}, 0);
        chk("clr_pending", {29'd0, pending}, 0);
        chk("clr_overflow", {31'd0, overflow}, 0);
        wave("clr_quiet", "00000000", "00000000");

        // Asynchronous reset mid-HIGH, between clock edges.
        trig = 1'b1;
        tick();
        tick();
        trig = 1'b0;
        chk("arst_pre_q", {31'd0, q}, 1);
        chk("arst_pre_pending", {29'd0, pending}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_q", {31'd0, q}, 0);
        chk("arst_pending", {29'd0, pending}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        #3 rst_n = 1'b1;
        tick();
        wave("arst_idle", "00000", "00000");
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("arst_new_q", {31'd0, q}, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
